// File: rtl/lighthouse_pkg.sv
// lighthouse_pkg
// Shared constants and types for the Lighthouse v1 optical waveform emitter:
// sync code base, the per-frequency sync unit, the phase encoding and the
// frame state enumeration. No ports; imported by the emitter and its sync encoder.
package lighthouse_pkg;

    // Sync pulse length in units is SYNC_BASE_CODE + {skip, data, axis}.
    localparam int unsigned SYNC_BASE_CODE = 6;

    // Frame phase: bit 1 selects the active lighthouse (0=A, 1=B),
    // bit 0 clear means the axis bit carried in the sync codes is 1.
    localparam logic [1:0] PH_A_AX1 = 2'd0;
    localparam logic [1:0] PH_A_AX0 = 2'd1;
    localparam logic [1:0] PH_B_AX1 = 2'd2;
    localparam logic [1:0] PH_B_AX0 = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC0,
        ST_GAP0,
        ST_SYNC1,
        ST_WAIT_SWEEP,
        ST_SWEEP,
        ST_TAIL
    } state_e;

    // Clocks per sync unit: 512 clocks at 48 MHz, scaled with the clock rate.
    function automatic int unsigned sync_unit(input int unsigned mhz);
        return (512 * mhz) / 48;
    endfunction

endpackage

// File: rtl/lighthouse_sync_encode.sv
// lighthouse_sync_encode
// Combinational sync pulse encoder: turns the three sync flags into the low
// time of the sync pulse in clocks. Inverse of the sensor's sync decoder.
// Ports:
//   skip_i  - skip flag (1 = this lighthouse is not sweeping this frame)
//   data_i  - OOTX data bit carried by this sync
//   axis_i  - axis bit carried by this sync
//   len_o   - pulse length in clocks, WIDTH+1 bits
module lighthouse_sync_encode
    import lighthouse_pkg::*;
#(
    parameter int MHZ   = 48,
    parameter int WIDTH = 20
) (
    input  logic             skip_i,
    input  logic             data_i,
    input  logic             axis_i,
    output logic [WIDTH:0]   len_o
);

    localparam int          TW   = WIDTH + 1;
    localparam int unsigned UNIT = sync_unit(MHZ);

    logic [3:0] code;

    assign code  = 4'(SYNC_BASE_CODE) + {1'b0, skip_i, data_i, axis_i};
    assign len_o = TW'(code) * TW'(UNIT);

endmodule

// File: rtl/lighthouse_emitter.sv
// lighthouse_emitter
// Emits a Lighthouse v1 frame on one active-low pin: sync0 (A), sync1 (B),
// then one sweep pulse centred a commanded number of clocks after the sync1
// rising edge. Frames repeat back to back while enable is held.
// Ports:
//   clk, reset    - clock and synchronous active-high reset
//   enable        - start and continue frames (sampled at frame boundaries)
//   angle         - sweep midpoint in clocks after the sync1 rising edge
//   ootx          - OOTX bits: [0] sent in sync0, [1] sent in sync1
//   pin           - emitted waveform, idles high
//   frame_strobe  - one-cycle pulse in the cycle angle/ootx are latched (t=0)
//   phase         - phase of the current frame
//   angle_err     - one-cycle pulse at t=1 when the latched angle is unusable
//   busy          - high while a frame is in progress
module lighthouse_emitter
    import lighthouse_pkg::*;
#(
    parameter int MHZ          = 48,
    parameter int WIDTH        = 20,
    parameter int ANGLE_BITS   = 20,
    parameter int FRAME_CLOCKS = 400000,
    parameter int SYNC_GAP     = 19200,
    parameter int SWEEP_WIDTH  = 480,
    parameter int GUARD        = 768
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [ANGLE_BITS-1:0] angle,
    input  logic [1:0]            ootx,
    output logic                  pin,
    output logic                  frame_strobe,
    output logic [1:0]            phase,
    output logic                  angle_err,
    output logic                  busy
);

    // All time arithmetic carries one spare bit so sums never wrap.
    localparam int TW = WIDTH + 1;
    localparam logic [TW-1:0] T_GAP     = TW'(SYNC_GAP);
    localparam logic [TW-1:0] T_LAST    = TW'(FRAME_CLOCKS - 1);
    localparam logic [TW-1:0] HALF_SW   = TW'(SWEEP_WIDTH / 2);
    localparam logic [TW-1:0] FULL_SW   = TW'(SWEEP_WIDTH);
    localparam logic [TW-1:0] MIN_ANGLE = TW'(GUARD + SWEEP_WIDTH / 2);
    localparam logic [TW-1:0] MAX_END   = TW'(FRAME_CLOCKS - GUARD);

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      t_q, t_d;
    logic [1:0]            phase_q, phase_d;
    logic                  strobe_q;
    logic                  err_q;
    logic                  valid_q;
    logic [ANGLE_BITS-1:0] angle_q;
    logic [1:0]            ootx_q;
    logic                  start;

    logic                  lh_b;
    logic                  axis;
    logic [TW-1:0]         len0, len1;
    logic [TW-1:0]         t_ext, t_nx;
    logic [TW-1:0]         t1, angle_ext, sweep_start, sweep_end;
    logic                  range_ok;

    assign lh_b = (phase_q == PH_B_AX1) || (phase_q == PH_B_AX0);
    assign axis = (phase_q == PH_A_AX1) || (phase_q == PH_B_AX1);

    // Both encoders see only latched inputs and the frame's phase, so the
    // lengths stay fixed for the whole frame.
    lighthouse_sync_encode #(.MHZ(MHZ), .WIDTH(WIDTH)) u_enc0 (
        .skip_i (lh_b),
        .data_i (ootx_q[0]),
        .axis_i (axis),
        .len_o  (len0)
    );

    lighthouse_sync_encode #(.MHZ(MHZ), .WIDTH(WIDTH)) u_enc1 (
        .skip_i (!lh_b),
        .data_i (ootx_q[1]),
        .axis_i (axis),
        .len_o  (len1)
    );

    assign t_ext       = {1'b0, t_q};
    assign t_nx        = t_ext + TW'(1);
    assign angle_ext   = TW'(angle_q);
    assign t1          = T_GAP + len1;
    // Sweep is centred on t1 + angle; only used when range_ok held at t=0.
    assign sweep_start = t1 + angle_ext - HALF_SW;
    assign sweep_end   = sweep_start + FULL_SW;
    assign range_ok    = (angle_ext >= MIN_ANGLE) &&
                         (t1 + angle_ext + HALF_SW <= MAX_END);

    // Next-state: each state ends the cycle before its boundary time so the
    // pin level in a cycle is decided by state_q alone.
    always_comb begin
        state_d = state_q;
        t_d     = t_q + WIDTH'(1);
        phase_d = phase_q;
        start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                t_d = '0;
                if (enable) begin
                    start   = 1'b1;
                    state_d = ST_SYNC0;
                end
            end
            ST_SYNC0: begin
                if (t_nx == len0) state_d = ST_GAP0;
            end
            ST_GAP0: begin
                if (t_nx == T_GAP) state_d = ST_SYNC1;
            end
            ST_SYNC1: begin
                if (t_nx == t1) state_d = valid_q ? ST_WAIT_SWEEP : ST_TAIL;
            end
            ST_WAIT_SWEEP: begin
                if (t_nx == sweep_start) state_d = ST_SWEEP;
            end
            ST_SWEEP: begin
                if (t_nx == sweep_end) state_d = ST_TAIL;
            end
            ST_TAIL: begin
                if (t_ext == T_LAST) begin
                    t_d     = '0;
                    phase_d = phase_q + 2'd1;
                    if (enable) begin
                        start   = 1'b1;
                        state_d = ST_SYNC0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            t_q      <= '0;
            phase_q  <= PH_A_AX1;
            strobe_q <= 1'b0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            phase_q  <= phase_d;
            strobe_q <= start;
            // strobe_q marks t=0, where the latched values are first visible.
            err_q    <= strobe_q && !range_ok;
            if (strobe_q) valid_q <= range_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            angle_q <= angle;
            ootx_q  <= ootx;
        end
    end

    assign pin          = !((state_q == ST_SYNC0) || (state_q == ST_SYNC1) ||
                            (state_q == ST_SWEEP));
    assign busy         = (state_q != ST_IDLE);
    assign frame_strobe = strobe_q;
    assign phase        = phase_q;
    assign angle_err    = err_q;

endmodule

// File: tb/tb_lighthouse_emitter.sv
module tb_lighthouse_emitter;

    localparam int MHZ  = 6;
    localparam int W    = 12;
    localparam int AB   = 12;
    localparam int FR   = 3000;
    localparam int SG   = 1200;
    localparam int SW   = 60;
    localparam int GD   = 96;
    localparam int UNIT = (512 * MHZ) / 48;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [AB-1:0] angle;
    logic [1:0]    ootx;
    logic          pin;
    logic          frame_strobe;
    logic [1:0]    phase;
    logic          angle_err;
    logic          busy;

    lighthouse_emitter #(
        .MHZ(MHZ), .WIDTH(W), .ANGLE_BITS(AB), .FRAME_CLOCKS(FR),
        .SYNC_GAP(SG), .SWEEP_WIDTH(SW), .GUARD(GD)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .angle(angle), .ootx(ootx),
        .pin(pin), .frame_strobe(frame_strobe), .phase(phase),
        .angle_err(angle_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: frame described by its start, its latched inputs and
    // the time offset within it.
    logic       m_busy = 1'b0;
    int         m_t = 0;
    logic [1:0] m_phase = 2'd0;
    int         m_angle = 0;
    logic [1:0] m_ootx = 2'd0;
    int         m_len0 = 0, m_len1 = 0;
    logic       m_valid = 1'b0;
    logic       m_strobe = 1'b0;
    logic       m_err = 1'b0;

    // Behavioural photodiode sensor decoding the actual pin.
    logic prev_pin = 1'b1;
    int   s_fall = 0, s_nsync = 0, s_code0 = 0, s_code1 = 0;
    int   s_rise1 = 0, s_nsweep = 0, s_angle = 0;

    function automatic int sync_len(input logic s, input logic d, input logic a);
        return (6 + 4 * int'(s) + 2 * int'(d) + int'(a)) * UNIT;
    endfunction

    function automatic int max_angle(input logic [1:0] ph, input logic [1:0] oo);
        return FR - GD - SW / 2 - (SG + sync_len(!ph[1], oo[1], !ph[0]));
    endfunction

    task automatic start_frame();
        m_busy   = 1'b1;
        m_t      = 0;
        m_strobe = 1'b1;
        m_angle  = int'(angle);
        m_ootx   = ootx;
        m_len0   = sync_len(m_phase[1], m_ootx[0], !m_phase[0]);
        m_len1   = sync_len(!m_phase[1], m_ootx[1], !m_phase[0]);
        m_valid  = (m_angle >= GD + SW / 2) &&
                   (SG + m_len1 + m_angle + SW / 2 <= FR - GD);
    endtask

    task automatic model_edge();
        m_strobe = 1'b0;
        m_err    = 1'b0;
        if (reset) begin
            m_busy  = 1'b0;
            m_t     = 0;
            m_phase = 2'd0;
        end else if (m_busy) begin
            if (m_t == FR - 1) begin
                m_phase = m_phase + 2'd1;
                if (enable) start_frame();
                else m_busy = 1'b0;
            end else begin
                m_t++;
                if (m_t == 1 && !m_valid) m_err = 1'b1;
            end
        end else if (enable) begin
            start_frame();
        end
    endtask

    function automatic logic exp_pin();
        int t1, ss;
        if (!m_busy) return 1'b1;
        t1 = SG + m_len1;
        ss = t1 + m_angle - SW / 2;
        if (m_t < m_len0) return 1'b0;
        if (m_t >= SG && m_t < t1) return 1'b0;
        if (m_valid && m_t >= ss && m_t < ss + SW) return 1'b0;
        return 1'b1;
    endfunction

    task automatic finish_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic sensor();
        int len;
        if (m_strobe) begin
            s_nsync  = 0;
            s_nsweep = 0;
        end
        if (prev_pin && !pin) s_fall = cyc;
        if (!prev_pin && pin) begin
            len = cyc - s_fall;
            if (len > 2 * SW) begin
                if (s_nsync == 0) s_code0 = len / UNIT - 6;
                else s_code1 = len / UNIT - 6;
                s_nsync++;
                s_rise1 = cyc;
            end else begin
                s_nsweep++;
                s_angle = (s_fall + cyc) / 2 - s_rise1;
            end
        end
        prev_pin = pin;
    endtask

    task automatic sensor_check();
        chk("sensor_nsync", s_nsync, 2);
        chk("sensor_sync0_code", s_code0, {29'd0, m_phase[1], m_ootx[0], !m_phase[0]});
        chk("sensor_sync1_code", s_code1, {29'd0, !m_phase[1], m_ootx[1], !m_phase[0]});
        chk("sensor_nsweep", s_nsweep, m_valid ? 1 : 0);
        if (m_valid) chk("sensor_angle", s_angle, m_angle);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        chk("pin", pin, exp_pin());
        chk("busy", busy, m_busy);
        chk("frame_strobe", frame_strobe, m_strobe);
        chk("phase", phase, m_phase);
        chk("angle_err", angle_err, m_err);
        sensor();
        if (m_busy && m_t == FR - 1) sensor_check();
        if (n_fail > 40) finish_run();
    endtask

    task automatic step_rand(input int n);
        for (int i = 0; i < n; i++) begin
            angle = AB'($urandom_range(0, 4095));
            ootx  = 2'($urandom);
            step();
        end
    endtask

    // Expects the model idle with enable high, or on the last cycle of a frame.
    task automatic frame(input int ang, input logic [1:0] oo);
        angle = AB'(ang);
        ootx  = oo;
        step();
        step_rand(FR - 1);
    endtask

    initial begin
        int ma;
        reset  = 1'b1;
        enable = 1'b0;
        angle  = '0;
        ootx   = 2'b00;
        repeat (3) step();
        reset = 1'b0;
        step();
        step();

        enable = 1'b1;
        frame(700, 2'b00);
        repeat (3) frame(700, 2'b01);
        frame(20, 2'b01);
        frame(126, 2'b10);
        frame(125, 2'b11);
        ma = max_angle(m_phase + 2'd1, 2'b00);
        frame(ma, 2'b00);
        ma = max_angle(m_phase + 2'd1, 2'b00);
        frame(ma + 1, 2'b00);
        repeat (2) frame($urandom_range(0, 1100), 2'($urandom));

        // enable dropped mid-frame: frame completes, then idles
        angle = AB'(600);
        ootx  = 2'b10;
        step();
        step_rand(1499);
        enable = 1'b0;
        step_rand(FR - 1 - 1499);
        step_rand(5);
        enable = 1'b1;
        angle  = AB'(600);
        ootx   = 2'b01;
        step();

        // reset while the sweep pulse is low
        for (int i = 0; i < FR && !(m_busy && m_t == SG + m_len1 + m_angle); i++) step_rand(1);
        chk("sweep_reached", pin, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        angle = AB'(400);
        ootx  = 2'b00;
        step();
        step_rand(FR - 1);

        finish_run();
    end

endmodule
